// File: rtl/vending_machine_multi.sv
// vending_machine_multi: N-slot vending controller with per-slot stock,
// cancel/refund and serial greedy change return.
module vending_machine_multi #(
  parameter int NUM_PRODUCTS = 4,
  parameter int CREDIT_W = 8,
  parameter int MAX_CREDIT = 100,
  parameter logic [NUM_PRODUCTS*CREDIT_W-1:0] PRICES =
    {8'd25, 8'd15, 8'd12, 8'd10},
  parameter int STOCK_W = 4,
  parameter int INIT_STOCK = 5
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    coin_valid,
  input  logic [1:0]              coin_type,
  input  logic                    sel_valid,
  input  logic [3:0]              sel_id,
  input  logic                    cancel,
  input  logic                    restock_valid,
  input  logic [3:0]              restock_id,
  input  logic [STOCK_W-1:0]      restock_qty,
  output logic [CREDIT_W-1:0]     credit,
  output logic                    dispense,
  output logic [3:0]              dispense_id,
  output logic                    change_valid,
  output logic [3:0]              change_value,
  output logic                    coin_reject,
  output logic                    sel_error,
  output logic [1:0]              err_code,
  output logic                    busy,
  output logic [NUM_PRODUCTS-1:0] sold_out
);

  localparam int IDW = (NUM_PRODUCTS > 1) ? $clog2(NUM_PRODUCTS) : 1;
  localparam logic [STOCK_W-1:0] STOCK_MAX = '1;

  typedef enum logic [1:0] {IDLE, VEND, CHANGE} state_t;

  state_t state, state_n;
  logic [CREDIT_W-1:0] credit_n;
  logic [STOCK_W-1:0] stock   [NUM_PRODUCTS];
  logic [STOCK_W-1:0] stock_n [NUM_PRODUCTS];
  logic [CREDIT_W-1:0] price_tab [NUM_PRODUCTS];

  logic [IDW-1:0] sel_idx, rs_idx;
  logic sel_ok, rs_ok;
  logic [CREDIT_W-1:0] price;
  logic [3:0] coin_val, chg_coin;
  logic [CREDIT_W:0] sum;
  logic [1:0] sel_err;
  logic idle, sel_take, vend_go, cancel_go, coin_ok;
  logic [STOCK_W:0] stock_sum;

  logic dispense_n, change_valid_n, coin_reject_n, sel_error_n;
  logic [3:0] dispense_id_n, change_value_n;
  logic [1:0] err_code_n;

  for (genvar g = 0; g < NUM_PRODUCTS; g++) begin : g_slot
    assign price_tab[g] = PRICES[g*CREDIT_W +: CREDIT_W];
    assign sold_out[g]  = (stock[g] == '0);
  end

  assign sel_idx = sel_id[IDW-1:0];
  assign rs_idx  = restock_id[IDW-1:0];
  assign sel_ok  = ({1'b0, sel_id} < 5'(NUM_PRODUCTS));
  assign rs_ok   = restock_valid &&
                   ({1'b0, restock_id} < 5'(NUM_PRODUCTS));
  assign price   = price_tab[sel_idx];
  assign idle    = (state == IDLE);
  assign busy    = !idle;

  always_comb begin
    coin_val = 4'd1;
    unique case (coin_type)
      2'd0: coin_val = 4'd1;
      2'd1: coin_val = 4'd2;
      2'd2: coin_val = 4'd5;
      2'd3: coin_val = 4'd10;
    endcase
  end

  // Wide sum so a near-ceiling credit cannot wrap past the limit check
  assign sum = {1'b0, credit} + (CREDIT_W+1)'(coin_val);

  always_comb begin
    chg_coin = 4'd1;
    if (credit >= CREDIT_W'(10))     chg_coin = 4'd10;
    else if (credit >= CREDIT_W'(5)) chg_coin = 4'd5;
    else if (credit >= CREDIT_W'(2)) chg_coin = 4'd2;
  end

  always_comb begin
    sel_err = 2'd0;
    if (!sel_ok)                    sel_err = 2'd1;
    else if (stock[sel_idx] == '0)  sel_err = 2'd2;
    else if (credit < price)        sel_err = 2'd3;
  end

  assign cancel_go = idle && cancel && (credit != '0);
  assign sel_take  = idle && !cancel && sel_valid;
  assign vend_go   = sel_take && (sel_err == 2'd0);
  assign coin_ok   = idle && !cancel && !sel_valid && coin_valid &&
                     (sum <= (CREDIT_W+1)'(MAX_CREDIT));

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      credit       <= '0;
      for (int i = 0; i < NUM_PRODUCTS; i++)
        stock[i] <= STOCK_W'(INIT_STOCK);
      dispense     <= 1'b0;
      dispense_id  <= 4'd0;
      change_valid <= 1'b0;
      change_value <= 4'd0;
      coin_reject  <= 1'b0;
      sel_error    <= 1'b0;
      err_code     <= 2'd0;
    end else begin
      state        <= state_n;
      credit       <= credit_n;
      stock        <= stock_n;
      dispense     <= dispense_n;
      dispense_id  <= dispense_id_n;
      change_valid <= change_valid_n;
      change_value <= change_value_n;
      coin_reject  <= coin_reject_n;
      sel_error    <= sel_error_n;
      err_code     <= err_code_n;
    end
  end

  always_comb begin
    state_n  = state;
    credit_n = credit;
    unique case (state)
      IDLE: begin
        if (cancel_go) begin
          state_n = CHANGE;
        end else if (vend_go) begin
          state_n  = VEND;
          credit_n = credit - price;
        end else if (coin_ok) begin
          credit_n = sum[CREDIT_W-1:0];
        end
      end
      VEND: state_n = (credit != '0) ? CHANGE : IDLE;
      // Zero credit here is the tail cycle after the last coin went out
      CHANGE: begin
        if (credit == '0) state_n = IDLE;
        else credit_n = credit - CREDIT_W'(chg_coin);
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    stock_sum = '0;
    for (int i = 0; i < NUM_PRODUCTS; i++) begin
      stock_sum = {1'b0, stock[i]};
      if (rs_ok && rs_idx == IDW'(i))
        stock_sum = stock_sum + {1'b0, restock_qty};
      if (vend_go && sel_idx == IDW'(i))
        stock_sum = stock_sum - (STOCK_W+1)'(1);
      stock_n[i] = (stock_sum > {1'b0, STOCK_MAX}) ?
                   STOCK_MAX : stock_sum[STOCK_W-1:0];
    end
  end

  always_comb begin
    dispense_n     = vend_go;
    dispense_id_n  = vend_go ? sel_id : 4'd0;
    change_valid_n = (state == CHANGE) && (credit != '0);
    change_value_n = change_valid_n ? chg_coin : 4'd0;
    coin_reject_n  = coin_valid && !coin_ok;
    sel_error_n    = sel_take && (sel_err != 2'd0);
    err_code_n     = sel_error_n ? sel_err : 2'd0;
  end

endmodule

// File: tb/tb_vending_machine_multi.sv
// Directed self-checking bench for vending_machine_multi.
// Slot prices: 0=10, 1=12, 2=15, 3=25; every slot starts with 5.
module tb_vending_machine_multi;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       coin_valid = 1'b0;
  logic [1:0] coin_type = 2'd0;
  logic       sel_valid = 1'b0;
  logic [3:0] sel_id = 4'd0;
  logic       cancel = 1'b0;
  logic       restock_valid = 1'b0;
  logic [3:0] restock_id = 4'd0;
  logic [3:0] restock_qty = 4'd0;
  logic [7:0] credit;
  logic       dispense;
  logic [3:0] dispense_id;
  logic       change_valid;
  logic [3:0] change_value;
  logic       coin_reject;
  logic       sel_error;
  logic [1:0] err_code;
  logic       busy;
  logic [3:0] sold_out;

  int n_pass = 0;
  int n_total = 0;

  vending_machine_multi dut (
    .clk(clk), .reset(reset),
    .coin_valid(coin_valid), .coin_type(coin_type),
    .sel_valid(sel_valid), .sel_id(sel_id),
    .cancel(cancel),
    .restock_valid(restock_valid), .restock_id(restock_id),
    .restock_qty(restock_qty),
    .credit(credit), .dispense(dispense),
    .dispense_id(dispense_id),
    .change_valid(change_valid), .change_value(change_value),
    .coin_reject(coin_reject), .sel_error(sel_error),
    .err_code(err_code), .busy(busy), .sold_out(sold_out)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic coin(input logic [1:0] t);
    coin_valid = 1'b1; coin_type = t;
    tick;
    coin_valid = 1'b0;
  endtask

  task automatic sel(input logic [3:0] id);
    sel_valid = 1'b1; sel_id = id;
    tick;
    sel_valid = 1'b0;
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    cancel = 1'b1;
    tick;
    cancel = 1'b0;
    while (busy && n < 40) begin
      tick;
      n++;
    end
    n_total++;
    if (busy !== 1'b0 || credit !== 8'd0)
      $display("FAIL %s_drain: busy=%0b credit=%0d want busy=0 credit=0",
               nm, busy, credit);
    else n_pass++;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick; tick;
    n_total++;
    if (credit !== 8'd0 || busy !== 1'b0 || sold_out !== 4'd0)
      $display("FAIL reset_state: credit=%0d busy=%0b sold_out=%b want 0/0/0000",
               credit, busy, sold_out);
    else n_pass++;
    n_total++;
    if ({dispense, change_valid, coin_reject, sel_error} !== 4'd0 ||
        dispense_id !== 4'd0 || change_value !== 4'd0 || err_code !== 2'd0)
      $display("FAIL reset_pulses: d=%0b cv=%0b cr=%0b se=%0b want all 0",
               dispense, change_valid, coin_reject, sel_error);
    else n_pass++;
    reset = 1'b0;
    tick;
    n_total++;
    if (credit !== 8'd0 || busy !== 1'b0)
      $display("FAIL reset_release: credit=%0d busy=%0b want 0/0",
               credit, busy);
    else n_pass++;
  endtask

  task automatic test_buy_change;
    logic [7:0] exp_c [3];
    logic [1:0] types [3];
    exp_c = '{8'd5, 8'd10, 8'd12};
    types = '{2'd2, 2'd2, 2'd1};
    for (int i = 0; i < 3; i++) begin
      coin(types[i]);
      n_total++;
      if (credit !== exp_c[i])
        $display("FAIL buy_coin%0d: credit=%0d want %0d", i, credit, exp_c[i]);
      else n_pass++;
    end
    sel(4'd0);
    n_total++;
    if (dispense !== 1'b1 || dispense_id !== 4'd0 || credit !== 8'd2 ||
        busy !== 1'b1)
      $display("FAIL buy_vend: d=%0b id=%0d credit=%0d busy=%0b want 1/0/2/1",
               dispense, dispense_id, credit, busy);
    else n_pass++;
    tick;
    n_total++;
    if (dispense !== 1'b0 || change_valid !== 1'b0 || busy !== 1'b1)
      $display("FAIL buy_enter_change: d=%0b cv=%0b busy=%0b want 0/0/1",
               dispense, change_valid, busy);
    else n_pass++;
    tick;
    n_total++;
    if (change_valid !== 1'b1 || change_value !== 4'd2 || credit !== 8'd0)
      $display("FAIL buy_change: cv=%0b val=%0d credit=%0d want 1/2/0",
               change_valid, change_value, credit);
    else n_pass++;
    tick;
    n_total++;
    if (change_valid !== 1'b0 || busy !== 1'b0 || credit !== 8'd0)
      $display("FAIL buy_idle: cv=%0b busy=%0b credit=%0d want 0/0/0",
               change_valid, busy, credit);
    else n_pass++;
  endtask

  task automatic test_insufficient;
    coin(2'd3); coin(2'd1);
    sel(4'd3);
    n_total++;
    if (sel_error !== 1'b1 || err_code !== 2'd3 || credit !== 8'd12 ||
        busy !== 1'b0 || dispense !== 1'b0)
      $display("FAIL insuff_err: se=%0b ec=%0d credit=%0d busy=%0b want 1/3/12/0",
               sel_error, err_code, credit, busy);
    else n_pass++;
    cancel = 1'b1;
    tick;
    cancel = 1'b0;
    n_total++;
    if (busy !== 1'b1 || change_valid !== 1'b0 || sel_error !== 1'b0)
      $display("FAIL cancel_enter: busy=%0b cv=%0b se=%0b want 1/0/0",
               busy, change_valid, sel_error);
    else n_pass++;
    tick;
    n_total++;
    if (change_valid !== 1'b1 || change_value !== 4'd10 || credit !== 8'd2)
      $display("FAIL cancel_coin10: cv=%0b val=%0d credit=%0d want 1/10/2",
               change_valid, change_value, credit);
    else n_pass++;
    tick;
    n_total++;
    if (change_valid !== 1'b1 || change_value !== 4'd2 || credit !== 8'd0)
      $display("FAIL cancel_coin2: cv=%0b val=%0d credit=%0d want 1/2/0",
               change_valid, change_value, credit);
    else n_pass++;
    tick;
    n_total++;
    if (change_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL cancel_done: cv=%0b busy=%0b want 0/0",
               change_valid, busy);
    else n_pass++;
  endtask

  task automatic test_invalid_id;
    coin(2'd3);
    sel(4'd5);
    n_total++;
    if (sel_error !== 1'b1 || err_code !== 2'd1 || credit !== 8'd10)
      $display("FAIL invalid_id: se=%0b ec=%0d credit=%0d want 1/1/10",
               sel_error, err_code, credit);
    else n_pass++;
    drain("invalid");
  endtask

  task automatic test_ceiling;
    for (int i = 0; i < 9; i++) coin(2'd3);
    coin(2'd2); coin(2'd1); coin(2'd0);
    n_total++;
    if (credit !== 8'd98 || coin_reject !== 1'b0)
      $display("FAIL ceil_fill: credit=%0d cr=%0b want 98/0",
               credit, coin_reject);
    else n_pass++;
    coin(2'd2);
    n_total++;
    if (coin_reject !== 1'b1 || credit !== 8'd98)
      $display("FAIL ceil_over5: cr=%0b credit=%0d want 1/98",
               coin_reject, credit);
    else n_pass++;
    coin(2'd1);
    n_total++;
    if (coin_reject !== 1'b0 || credit !== 8'd100)
      $display("FAIL ceil_exact: cr=%0b credit=%0d want 0/100",
               coin_reject, credit);
    else n_pass++;
    coin(2'd0);
    n_total++;
    if (coin_reject !== 1'b1 || credit !== 8'd100)
      $display("FAIL ceil_over1: cr=%0b credit=%0d want 1/100",
               coin_reject, credit);
    else n_pass++;
    drain("ceiling");
  endtask

  task automatic test_sold_out;
    for (int k = 0; k < 5; k++) begin
      coin(2'd3); coin(2'd1);
      sel(4'd1);
      n_total++;
      if (dispense !== 1'b1 || dispense_id !== 4'd1)
        $display("FAIL so_buy%0d: d=%0b id=%0d want 1/1",
                 k, dispense, dispense_id);
      else n_pass++;
      tick;
    end
    n_total++;
    if (sold_out !== 4'b0010 || busy !== 1'b0)
      $display("FAIL so_flag: sold_out=%b busy=%0b want 0010/0",
               sold_out, busy);
    else n_pass++;
    coin(2'd3); coin(2'd1);
    sel(4'd1);
    n_total++;
    if (sel_error !== 1'b1 || err_code !== 2'd2 || credit !== 8'd12)
      $display("FAIL so_err: se=%0b ec=%0d credit=%0d want 1/2/12",
               sel_error, err_code, credit);
    else n_pass++;
    restock_valid = 1'b1; restock_id = 4'd1; restock_qty = 4'd3;
    tick;
    restock_valid = 1'b0;
    n_total++;
    if (sold_out[1] !== 1'b0)
      $display("FAIL so_restock: sold_out=%b want 0000", sold_out);
    else n_pass++;
    // same-edge restock and vend: 3 + 3 - 1 = 5
    restock_valid = 1'b1; restock_qty = 4'd3;
    sel_valid = 1'b1; sel_id = 4'd1;
    tick;
    restock_valid = 1'b0; sel_valid = 1'b0;
    n_total++;
    if (dispense !== 1'b1 || credit !== 8'd0)
      $display("FAIL so_rs_vend: d=%0b credit=%0d want 1/0",
               dispense, credit);
    else n_pass++;
    tick;
    for (int k = 0; k < 4; k++) begin
      coin(2'd3); coin(2'd1);
      sel(4'd1);
      tick;
    end
    n_total++;
    if (sold_out[1] !== 1'b0)
      $display("FAIL so_net_4left: sold_out=%b want bit1=0", sold_out);
    else n_pass++;
    coin(2'd3); coin(2'd1);
    sel(4'd1);
    tick;
    n_total++;
    if (sold_out[1] !== 1'b1)
      $display("FAIL so_net_5: sold_out=%b want bit1=1", sold_out);
    else n_pass++;
  endtask

  task automatic test_coin_with_sel;
    coin(2'd2); coin(2'd1); coin(2'd0);
    coin_valid = 1'b1; coin_type = 2'd2;
    sel_valid = 1'b1; sel_id = 4'd0;
    tick;
    coin_valid = 1'b0; sel_valid = 1'b0;
    n_total++;
    if (coin_reject !== 1'b1 || sel_error !== 1'b1 || err_code !== 2'd3 ||
        credit !== 8'd8)
      $display("FAIL cs_oldcredit: cr=%0b se=%0b ec=%0d credit=%0d want 1/1/3/8",
               coin_reject, sel_error, err_code, credit);
    else n_pass++;
    coin(2'd1); coin(2'd1);
    coin_valid = 1'b1; coin_type = 2'd3;
    sel_valid = 1'b1; sel_id = 4'd0;
    tick;
    coin_valid = 1'b0; sel_valid = 1'b0;
    n_total++;
    if (coin_reject !== 1'b1 || dispense !== 1'b1 || credit !== 8'd2)
      $display("FAIL cs_vend: cr=%0b d=%0b credit=%0d want 1/1/2",
               coin_reject, dispense, credit);
    else n_pass++;
    tick;
    coin(2'd3);
    n_total++;
    if (coin_reject !== 1'b1 || change_valid !== 1'b1 ||
        change_value !== 4'd2 || credit !== 8'd0)
      $display("FAIL cs_change_coin: cr=%0b cv=%0b val=%0d credit=%0d want 1/1/2/0",
               coin_reject, change_valid, change_value, credit);
    else n_pass++;
    tick;
    n_total++;
    if (coin_reject !== 1'b0 || change_valid !== 1'b0 || busy !== 1'b0 ||
        credit !== 8'd0)
      $display("FAIL cs_done: cr=%0b cv=%0b busy=%0b credit=%0d want 0/0/0/0",
               coin_reject, change_valid, busy, credit);
    else n_pass++;
  endtask

  task automatic test_reset_mid_change;
    coin(2'd3); coin(2'd2); coin(2'd1);
    n_total++;
    if (credit !== 8'd17)
      $display("FAIL rm_fill: credit=%0d want 17", credit);
    else n_pass++;
    cancel = 1'b1;
    tick;
    cancel = 1'b0;
    tick;
    n_total++;
    if (change_valid !== 1'b1 || change_value !== 4'd10 || credit !== 8'd7)
      $display("FAIL rm_first: cv=%0b val=%0d credit=%0d want 1/10/7",
               change_valid, change_value, credit);
    else n_pass++;
    reset = 1'b1;
    tick;
    n_total++;
    if (credit !== 8'd0 || busy !== 1'b0 || change_valid !== 1'b0 ||
        sold_out !== 4'd0)
      $display("FAIL rm_reset: credit=%0d busy=%0b cv=%0b so=%b want 0/0/0/0000",
               credit, busy, change_valid, sold_out);
    else n_pass++;
    reset = 1'b0;
    tick;
    n_total++;
    if (change_valid !== 1'b0 || credit !== 8'd0 || busy !== 1'b0)
      $display("FAIL rm_after: cv=%0b credit=%0d busy=%0b want 0/0/0",
               change_valid, credit, busy);
    else n_pass++;
    coin(2'd0);
    n_total++;
    if (credit !== 8'd1)
      $display("FAIL rm_coin: credit=%0d want 1", credit);
    else n_pass++;
  endtask

  initial begin
    test_reset;
    test_buy_change;
    test_insufficient;
    test_invalid_id;
    test_ceiling;
    test_sold_out;
    test_coin_with_sel;
    test_reset_mid_change;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
